// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with true-LRU replacement, a single
// outstanding line refill, and an INIT/FLUSH sweep that clears valid bits and resets LRU order.
module icache_assoc #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_hit,
  input  logic        flush,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned WayW = $clog2(WAYS);
  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned OffW = $clog2(LINE_WORDS);
  localparam int unsigned TagW = 32 - IdxW - OffW - 2;

  typedef enum logic [2:0] {
    StInit, StIdle, StLookup, StMissReq, StRefill, StResp, StFlush
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   sweep_q, sweep_d;
  logic [31:0]       addr_q, addr_d;
  logic [WayW-1:0]   victim_q, victim_d;
  logic [OffW-1:0]   beat_q, beat_d;
  logic              flush_pend_q, flush_pend_d;
  logic [31:0]       hit_count_q, hit_count_d;
  logic [31:0]       miss_count_q, miss_count_d;

  // Tag/state storage is read combinationally from the registered request address, so a
  // write at one edge is already visible to a same-set lookup in the following cycle.
  logic [TagW-1:0]   tag_q   [SETS][WAYS];
  logic              valid_q [SETS][WAYS];
  logic [WayW-1:0]   lru_q   [SETS][WAYS];
  logic [31:0]       data_q  [SETS][WAYS][LINE_WORDS];

  logic [IdxW-1:0]   idx;
  logic [TagW-1:0]   tag;
  logic [OffW-1:0]   off;
  logic              lookup_hit;
  logic [WayW-1:0]   hit_way;
  logic [WayW-1:0]   victim_sel;
  logic              found_inv;
  logic [WayW-1:0]   upd_way;
  logic [WayW-1:0]   upd_pos;
  logic [WayW-1:0]   lru_new [WAYS];
  logic              sweep_en, lru_we, fill_we, beat_we;
  logic              unused_addr_bits;

  assign idx = addr_q[OffW+2 +: IdxW];
  assign tag = addr_q[31 -: TagW];
  assign off = addr_q[2 +: OffW];
  assign unused_addr_bits = ^addr_q[1:0];

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        lookup_hit = 1'b1;
        hit_way    = WayW'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the least recently used one.
  always_comb begin
    victim_sel = '0;
    found_inv  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[idx][w]) begin
        found_inv  = 1'b1;
        victim_sel = WayW'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (lru_q[idx][w] == WayW'(WAYS - 1)) victim_sel = WayW'(w);
      end
    end
  end

  always_comb begin
    upd_way = (state_q == StRefill) ? victim_q : hit_way;
    upd_pos = lru_q[idx][upd_way];
    for (int w = 0; w < WAYS; w++) begin
      if (WayW'(w) == upd_way) begin
        lru_new[w] = '0;
      end else if (lru_q[idx][w] < upd_pos) begin
        lru_new[w] = lru_q[idx][w] + WayW'(1);
      end else begin
        lru_new[w] = lru_q[idx][w];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    addr_d        = addr_q;
    victim_d      = victim_q;
    beat_d        = beat_q;
    flush_pend_d  = flush_pend_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    resp_data     = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    sweep_en      = 1'b0;
    lru_we        = 1'b0;
    fill_we       = 1'b0;
    beat_we       = 1'b0;

    unique case (state_q)
      StInit, StFlush: begin
        sweep_en     = 1'b1;
        sweep_d      = sweep_q + IdxW'(1);
        flush_pend_d = 1'b0;
        if (sweep_q == IdxW'(SETS - 1)) state_d = StIdle;
      end
      StIdle: begin
        if (flush || flush_pend_q) begin
          state_d      = StFlush;
          flush_pend_d = 1'b0;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            addr_d  = req_addr;
            state_d = StLookup;
          end
        end
      end
      StLookup: begin
        if (lookup_hit) begin
          resp_valid  = 1'b1;
          resp_hit    = 1'b1;
          resp_data   = data_q[idx][hit_way][off];
          lru_we      = 1'b1;
          hit_count_d = hit_count_q + {31'b0, ~&hit_count_q};
          if (flush) begin
            state_d = StFlush;
          end else begin
            req_ready = 1'b1;
            if (req_valid) begin
              addr_d = req_addr;
            end else begin
              state_d = StIdle;
            end
          end
        end else begin
          miss_count_d = miss_count_q + {31'b0, ~&miss_count_q};
          victim_d     = victim_sel;
          state_d      = StMissReq;
          if (flush) flush_pend_d = 1'b1;
        end
      end
      StMissReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[31:OffW+2], {(OffW + 2){1'b0}}};
        if (flush) flush_pend_d = 1'b1;
        if (mem_req_ready) begin
          state_d = StRefill;
          beat_d  = '0;
        end
      end
      StRefill: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_rdata_valid) begin
          beat_we = 1'b1;
          beat_d  = beat_q + OffW'(1);
          if (beat_q == OffW'(LINE_WORDS - 1)) begin
            fill_we = 1'b1;
            lru_we  = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        resp_valid   = 1'b1;
        resp_data    = data_q[idx][victim_q][off];
        state_d      = (flush || flush_pend_q) ? StFlush : StIdle;
        flush_pend_d = 1'b0;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      sweep_q      <= '0;
      addr_q       <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      addr_q       <= addr_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Storage needs no reset: the INIT sweep establishes valid and LRU state.
  always_ff @(posedge clk) begin
    if (sweep_en) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[sweep_q][w] <= 1'b0;
        lru_q[sweep_q][w]   <= WayW'(w);
      end
    end
    if (lru_we) begin
      for (int w = 0; w < WAYS; w++) lru_q[idx][w] <= lru_new[w];
    end
    if (fill_we) begin
      tag_q[idx][victim_q]   <= tag;
      valid_q[idx][victim_q] <= 1'b1;
    end
    if (beat_we) data_q[idx][victim_q][beat_q] <= mem_rdata;
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: table of hit/miss/LRU vectors plus hand-written
// sequences for back-to-back hits, flush during refill, reset mid-refill and counter saturation.
module tb_icache_assoc;

  localparam int unsigned LW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_hit;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_assoc #(.WAYS(4), .SETS(64), .LINE_WORDS(LW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_hit        (resp_hit),
    .flush           (flush),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    logic        exp_hit;
    logic [31:0] exp_data;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request; serves a refill with words base+0..base+LW-1, optionally pulsing flush
  // during beat flush_beat. Returns at the negedge on which resp_valid is seen.
  task automatic access(input logic [31:0] a, input logic [31:0] base, input int flush_beat,
                        output logic hit, output logic [31:0] data,
                        output logic [31:0] maddr, output logic ok);
    ok = 1'b0; hit = 1'b0; data = '0; maddr = '1;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (resp_valid) begin
        hit  = resp_hit;
        data = resp_data;
        ok   = 1'b1;
        break;
      end
      if (mem_req_valid) begin
        maddr         = mem_req_addr;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < LW; b++) begin
          mem_rdata_valid = 1'b1;
          mem_rdata       = base + b;
          flush           = (b == flush_beat);
          @(negedge clk);
        end
        mem_rdata_valid = 1'b0;
        flush           = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic count_not_ready(output int n);
    n = 0;
    while (!req_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic        hit, ok;
    logic [31:0] data, maddr;
    int          n;

    vecs[0] = '{32'h0000_0000, 32'h0000_0B00, 1'b0, 32'h0000_0B00, 32'h0000_0000};
    vecs[1] = '{32'h0000_0400, 32'h0000_0B10, 1'b0, 32'h0000_0B10, 32'h0000_0400};
    vecs[2] = '{32'h0000_0800, 32'h0000_0B20, 1'b0, 32'h0000_0B20, 32'h0000_0800};
    vecs[3] = '{32'h0000_0C00, 32'h0000_0B30, 1'b0, 32'h0000_0B30, 32'h0000_0C00};
    vecs[4] = '{32'h0000_0004, 32'h0000_0000, 1'b1, 32'h0000_0B01, 32'h0000_0000};
    vecs[5] = '{32'h0000_1000, 32'h0000_0B40, 1'b0, 32'h0000_0B40, 32'h0000_1000};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0B00, 32'h0000_0000};
    vecs[7] = '{32'h0000_0800, 32'h0000_0000, 1'b1, 32'h0000_0B20, 32'h0000_0000};
    vecs[8] = '{32'h0000_0C08, 32'h0000_0000, 1'b1, 32'h0000_0B32, 32'h0000_0000};
    vecs[9] = '{32'h0000_0404, 32'h0000_0B50, 1'b0, 32'h0000_0B51, 32'h0000_0400};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);

    rst_n = 1'b1;
    count_not_ready(n);
    chk("init_not_ready_cycles", n, 64);
    chk("init_ready_after", req_ready, 1);

    // First miss
    access(32'h0000_0100, 32'h0000_00A0, -1, hit, data, maddr, ok);
    chk("m1_ok", ok, 1);
    chk("m1_maddr", maddr, 32'h0000_0100);
    chk("m1_data", data, 32'h0000_00A0);
    chk("m1_hit", hit, 0);

    // Back-to-back hits
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0104;
    chk("b2b_ready0", req_ready, 1);
    @(negedge clk);
    req_addr = 32'h0000_0108;
    chk("b2b_valid0", resp_valid, 1);
    chk("b2b_hit0", resp_hit, 1);
    chk("b2b_data0", resp_data, 32'h0000_00A1);
    chk("b2b_ready1", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_valid1", resp_valid, 1);
    chk("b2b_hit1", resp_hit, 1);
    chk("b2b_data1", resp_data, 32'h0000_00A2);
    @(negedge clk);
    chk("b2b_hit_count", hit_count, 2);
    chk("b2b_miss_count", miss_count, 1);

    // LRU table on set 0
    for (int i = 0; i < 10; i++) begin
      access(vecs[i].addr, vecs[i].base, -1, hit, data, maddr, ok);
      chk($sformatf("v%0d_ok", i), ok, 1);
      chk($sformatf("v%0d_hit", i), hit, vecs[i].exp_hit);
      chk($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      if (!vecs[i].exp_hit) chk($sformatf("v%0d_maddr", i), maddr, vecs[i].exp_maddr);
    end

    // Flush during third refill beat
    access(32'h0000_2004, 32'h0000_0C00, 2, hit, data, maddr, ok);
    chk("fl_ok", ok, 1);
    chk("fl_data", data, 32'h0000_0C01);
    chk("fl_hit", hit, 0);
    @(negedge clk);
    count_not_ready(n);
    chk("fl_not_ready_cycles", n, 64);
    access(32'h0000_2004, 32'h0000_0D00, -1, hit, data, maddr, ok);
    chk("fl_after_ok", ok, 1);
    chk("fl_after_hit", hit, 0);
    chk("fl_after_data", data, 32'h0000_0D01);

    // Reset after two of four beats
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_3008;
    chk("rr_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rr_lookup_no_resp", resp_valid, 0);
    @(negedge clk);
    chk("rr_mem_req_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'h0000_0E00;
    @(negedge clk);
    mem_rdata = 32'h0000_0E01;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rr_req_ready", req_ready, 0);
    chk("rr_resp_valid", resp_valid, 0);
    chk("rr_resp_data", resp_data, 0);
    chk("rr_mem_req_valid_rst", mem_req_valid, 0);
    chk("rr_mem_req_addr", mem_req_addr, 0);
    chk("rr_hit_count", hit_count, 0);
    chk("rr_miss_count", miss_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_not_ready(n);
    chk("rr_init_cycles", n, 64);
    access(32'h0000_3008, 32'h0000_0F00, -1, hit, data, maddr, ok);
    chk("rr_after_ok", ok, 1);
    chk("rr_after_hit", hit, 0);
    chk("rr_after_maddr", maddr, 32'h0000_3000);
    chk("rr_after_data", data, 32'h0000_0F02);

    // Miss counter saturation
    @(negedge clk);
    force dut.miss_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.miss_count_q;
    access(32'h0000_5000, 32'h0000_0700, -1, hit, data, maddr, ok);
    chk("sat_ok", ok, 1);
    chk("sat_hit", hit, 0);
    @(negedge clk);
    chk("sat_miss_count", miss_count, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
